instr_fetch_stage: RTL and testbench
====================================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width of PC and instruction.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_addr, output, WIDTH bits: fetch address, equal to the PC register.
REQ-007 SHALL have port imem_req_ready, input, 1 bit: the memory accepts the request.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit: instruction word returned.
REQ-009 SHALL have port imem_rsp_data, input, WIDTH bits: returned instruction word.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump taken; load a new PC.
REQ-011 SHALL have port redirect_pc, input, WIDTH bits: redirect target.
REQ-012 SHALL have port id_ready, input, 1 bit: decode/immediate-generation stage consumes the output.
REQ-013 SHALL have ports id_valid (1), id_instr (WIDTH), id_pc (WIDTH) and id_pc_plus4 (WIDTH), all outputs: the registered IF/ID payload.
REQ-014 SHALL have port misalign_err, output, 1 bit: misaligned redirect flag (see Configuration).

Function
REQ-015 SHALL keep at most one memory request outstanding; a request is accepted on a cycle with imem_req_valid=1 and imem_req_ready=1.
REQ-016 SHALL use states FETCH, WAIT, HOLD and DROP; imem_req_valid=1 only in FETCH.
REQ-017 FETCH: on acceptance, go to WAIT; otherwise hold imem_req_valid and imem_req_addr stable.
REQ-018 WAIT: on imem_rsp_valid, if id_valid=0 or id_ready=1, load id_instr=rsp_data, id_pc=PC, id_pc_plus4=PC+4 and id_valid=1, set PC=PC+4, and go to FETCH; otherwise capture the word in the one-entry skid buffer, set PC=PC+4, and go to HOLD.
REQ-019 HOLD: when id_ready=1, move the buffer into the IF/ID register and go to FETCH.
REQ-020 DROP: discard the next imem_rsp_valid word and go to FETCH.
REQ-021 Without a new load, id_ready=1 SHALL clear id_valid on the next edge; id_valid=1 with id_ready=0 SHALL hold the payload unchanged.
REQ-022 redirect_valid SHALL have highest priority: PC=redirect_pc, id_valid=0, skid buffer invalidated, in the same edge.
REQ-023 Redirect in WAIT without same-cycle response, or in FETCH with same-cycle acceptance -> DROP; redirect in WAIT with same-cycle response -> response discarded, go to FETCH; otherwise -> FETCH.
REQ-024 PC+4 SHALL wrap modulo 2^WIDTH (32'hFFFF_FFFC -> 32'h0).
REQ-025 imem_rsp_valid in FETCH or HOLD is a protocol error and SHALL be ignored.

Reset
REQ-026 reset_n=0 SHALL immediately force PC=RESET_PC, state FETCH, skid buffer invalid, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, misalign_err=0.
REQ-027 An outstanding request at reset assertion SHALL be abandoned; the first request after release is at RESET_PC.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN: when defined, a redirect with redirect_pc[1:0]!=0 SHALL set misalign_err=1 (sticky), flush as in REQ-022, and halt fetch (imem_req_valid=0) until reset or the next aligned redirect, which clears misalign_err.
REQ-029 When FETCH_MISALIGN_TRAP_EN is undefined, misalign_err SHALL be tied 0 and redirect_pc[1:0] SHALL be forced to 2'b00.

Structure
REQ-030 State encodings, RESET_PC default and the PC increment constant SHALL live in the shared defines file next to the instruction opcode defines.
REQ-031 The skid buffer SHALL be a sub-module fetch_skid_buf (data, pc, valid; load/unload).

Verification
REQ-032 Reset release, imem_req_ready=1, 1-cycle response 32'h00500093 -> first req_addr 0x0; id_instr=32'h00500093, id_pc=0x0, id_pc_plus4=0x4; next req_addr 0x4.
REQ-033 id_ready=0 for 5 cycles with a response arriving -> state HOLD, no new request, id payload stable; id_ready=1 -> buffered word presented next cycle, then request at PC+4.
REQ-034 Redirect to 0x100 in WAIT, response 3 cycles later -> that response is dropped; next request 0x100; id_valid stays 0 until the 0x100 word returns.
REQ-035 Redirect and response on the same edge in WAIT -> response discarded; next request is the redirect target.
REQ-036 PC at 32'hFFFF_FFFC fetched -> id_pc_plus4=0x0; next req_addr 0x0.
REQ-037 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err=1, imem_req_valid=0; redirect to 0x200 -> misalign_err=0, request 0x200. Without the macro -> request 0x100.

Source files
------------

// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset and
// increment constants, and the RV32I base opcode map used by the front end.
package instr_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INCR          = 4;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word and its PC while the
// IF/ID register is still occupied. Flush has priority over load/unload.
module fetch_skid_buf
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding a registered IF/ID payload.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirects set a sticky error and halt fetch.
//
// state | meaning
// FETCH | request presented at PC, waiting for acceptance
// WAIT  | request accepted, waiting for the instruction word
// HOLD  | word parked in the skid buffer until decode frees IF/ID
// DROP  | outstanding word belongs to a flushed path, discard on arrival
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pc_plus4,
  output logic             misalign_err
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INCR);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] redir_pc;
  logic             fetch_halt;
  logic             req_fire;

  logic             id_load, id_from_skid;
  logic             id_valid_q, id_valid_d;
  logic [WIDTH-1:0] id_instr_q, id_instr_d;
  logic [WIDTH-1:0] id_pc_q, id_pc_d;
  logic [WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [WIDTH-1:0] id_src_pc;

  logic             skid_load, skid_unload, skid_valid;
  logic [WIDTH-1:0] skid_data, skid_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign redir_pc = redirect_pc;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end

  assign fetch_halt   = misalign_q;
  assign misalign_err = misalign_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = |redirect_pc[1:0];
  assign redir_pc             = {redirect_pc[WIDTH-1:2], 2'b00};
  assign fetch_halt           = 1'b0;
  assign misalign_err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_load      = 1'b0;
    id_from_skid = 1'b0;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    if (redirect_valid) begin
      pc_d = redir_pc;
      // A word still in flight for the old path must be swallowed before refetching;
      // DROP without a response keeps waiting so only one request is ever outstanding.
      if ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rsp_valid) state_d = ST_DROP;
      else if (state_q == ST_FETCH && req_fire)                         state_d = ST_DROP;
      else                                                                state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: if (req_fire) state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            pc_d = pc_q + PC_STEP;
            if (!id_valid_q || id_ready) begin
              id_load = 1'b1;
              state_d = ST_FETCH;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (id_ready && skid_valid) begin
            id_load      = 1'b1;
            id_from_skid = 1'b1;
            skid_unload  = 1'b1;
            state_d      = ST_FETCH;
          end
        end
        ST_DROP: if (imem_rsp_valid) state_d = ST_FETCH;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (state_q == ST_FETCH && !fetch_halt) imem_req_valid = 1'b1;
  end

  assign imem_req_addr = pc_q;
  assign req_fire      = imem_req_valid && imem_req_ready;

  fetch_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (redirect_valid),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (imem_rsp_data),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .data_o   (skid_data),
    .pc_o     (skid_pc)
  );

  assign id_src_pc = id_from_skid ? skid_pc : pc_q;

  always_comb begin
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    if (redirect_valid) begin
      id_valid_d = 1'b0;
    end else if (id_load) begin
      id_valid_d    = 1'b1;
      id_instr_d    = id_from_skid ? skid_data : imem_rsp_data;
      id_pc_d       = id_src_pc;
      id_pc_plus4_d = id_src_pc + PC_STEP;
    end else if (id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: cycle vector table, directed corner sequences,
// then a randomized run scored against an in-order program-stream model.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        xv;
    logic [31:0] xpc;
    logic        idr;
    logic        e_qv;
    logic [31:0] e_qa;
    logic        e_iv;
    logic [31:0] e_ii;
    logic [31:0] e_ip;
    logic [31:0] e_ip4;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic xv, input logic [31:0] xpc, input logic idr,
                              input logic e_qv, input logic [31:0] e_qa, input logic e_iv,
                              input logic [31:0] e_ii, input logic [31:0] e_ip,
                              input logic [31:0] e_ip4);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.xv = xv; v.xpc = xpc; v.idr = idr;
    v.e_qv = e_qv; v.e_qa = e_qa; v.e_iv = e_iv; v.e_ii = e_ii; v.e_ip = e_ip; v.e_ip4 = e_ip4;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic xv, input logic [31:0] xpc, input logic idr);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    redirect_valid = xv;
    redirect_pc    = xpc;
    id_ready       = idr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] exp_pc;
  int          consumed;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        rdy rv rd            xv xpc         idr  qv qa          iv ii            ip          ip4
    tbl[0]  = mk(1, 0, 32'h0,        0, 32'h0,   0,   1, 32'h0,   0, 32'h0,        32'h0,   32'h0);
    tbl[1]  = mk(0, 1, 32'h00500093, 0, 32'h0,   1,   0, 32'h0,   0, 32'h0,        32'h0,   32'h0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 32'h0,   0,   1, 32'h4,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[3]  = mk(1, 0, 32'h0,        0, 32'h0,   0,   1, 32'h4,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[4]  = mk(0, 1, 32'hAAAA0001, 0, 32'h0,   0,   0, 32'h4,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[5]  = mk(1, 0, 32'h0,        0, 32'h0,   0,   0, 32'h8,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[6]  = mk(1, 0, 32'h0,        0, 32'h0,   0,   0, 32'h8,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[7]  = mk(1, 0, 32'h0,        0, 32'h0,   0,   0, 32'h8,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[8]  = mk(1, 0, 32'h0,        0, 32'h0,   0,   0, 32'h8,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[9]  = mk(1, 0, 32'h0,        0, 32'h0,   1,   0, 32'h8,   1, 32'h00500093, 32'h0,   32'h4);
    tbl[10] = mk(1, 0, 32'h0,        0, 32'h0,   1,   1, 32'h8,   1, 32'hAAAA0001, 32'h4,   32'h8);
    tbl[11] = mk(0, 0, 32'h0,        1, 32'h100, 1,   0, 32'h8,   0, 32'h0,        32'h0,   32'h0);
    tbl[12] = mk(1, 0, 32'h0,        0, 32'h0,   1,   0, 32'h100, 0, 32'h0,        32'h0,   32'h0);
    tbl[13] = mk(1, 0, 32'h0,        0, 32'h0,   1,   0, 32'h100, 0, 32'h0,        32'h0,   32'h0);
    tbl[14] = mk(1, 1, 32'hDEAD0008, 0, 32'h0,   1,   0, 32'h100, 0, 32'h0,        32'h0,   32'h0);
    tbl[15] = mk(1, 0, 32'h0,        0, 32'h0,   1,   1, 32'h100, 0, 32'h0,        32'h0,   32'h0);
    tbl[16] = mk(0, 1, 32'h00100113, 0, 32'h0,   1,   0, 32'h100, 0, 32'h0,        32'h0,   32'h0);
    tbl[17] = mk(1, 0, 32'h0,        0, 32'h0,   1,   1, 32'h104, 1, 32'h00100113, 32'h100, 32'h104);
    tbl[18] = mk(0, 1, 32'hBAD00104, 1, 32'h240, 1,   0, 32'h104, 0, 32'h0,        32'h0,   32'h0);
    tbl[19] = mk(0, 1, 32'hBAD0BAD0, 0, 32'h0,   1,   1, 32'h240, 0, 32'h0,        32'h0,   32'h0);
    tbl[20] = mk(1, 0, 32'h0,        0, 32'h0,   1,   1, 32'h240, 0, 32'h0,        32'h0,   32'h0);
    tbl[21] = mk(0, 1, 32'h12345678, 0, 32'h0,   0,   0, 32'h240, 0, 32'h0,        32'h0,   32'h0);
    tbl[22] = mk(0, 0, 32'h0,        0, 32'h0,   0,   1, 32'h244, 1, 32'h12345678, 32'h240, 32'h244);
    tbl[23] = mk(0, 0, 32'h0,        0, 32'h0,   1,   1, 32'h244, 1, 32'h12345678, 32'h240, 32'h244);
    tbl[24] = mk(0, 0, 32'h0,        0, 32'h0,   0,   1, 32'h244, 0, 32'h0,        32'h0,   32'h0);

    reset_n = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("reset req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("reset req_addr", imem_req_addr, 32'h0);
    chk("reset id_valid", {31'h0, id_valid}, 32'h0);
    chk("reset id_instr", id_instr, 32'h0);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset id_pc_plus4", id_pc_plus4, 32'h0);
    chk("reset misalign_err", {31'h0, misalign_err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].xv, tbl[i].xpc, tbl[i].idr);
      @(negedge clk);
      chk($sformatf("vec%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, tbl[i].e_qv});
      chk($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].e_qa);
      chk($sformatf("vec%0d id_valid", i), {31'h0, id_valid}, {31'h0, tbl[i].e_iv});
      chk($sformatf("vec%0d misalign_err", i), {31'h0, misalign_err}, 32'h0);
      if (tbl[i].e_iv) begin
        chk($sformatf("vec%0d id_instr", i), id_instr, tbl[i].e_ii);
        chk($sformatf("vec%0d id_pc", i), id_pc, tbl[i].e_ip);
        chk($sformatf("vec%0d id_pc_plus4", i), id_pc_plus4, tbl[i].e_ip4);
      end
      tick();
    end

    // PC wrap at the top of the address space
    drive(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
    tick();
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    chk("wrap req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("wrap req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 1, 32'h0000_0013, 0, 32'h0, 1);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("wrap id_valid", {31'h0, id_valid}, 32'h1);
    chk("wrap id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap id_pc_plus4", id_pc_plus4, 32'h0);
    chk("wrap next req_addr", imem_req_addr, 32'h0);
    tick();

    // Misaligned redirect
    drive(0, 0, 32'h0, 1, 32'h102, 1);
    tick();
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign err set", {31'h0, misalign_err}, 32'h1);
    chk("misalign req_valid low", {31'h0, imem_req_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("misalign halt holds", {31'h0, imem_req_valid}, 32'h0);
    chk("misalign err sticky", {31'h0, misalign_err}, 32'h1);
    tick();
    drive(0, 0, 32'h0, 1, 32'h200, 1);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    chk("realign err clear", {31'h0, misalign_err}, 32'h0);
    chk("realign req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("realign req_addr", imem_req_addr, 32'h200);
`else
    chk("misalign err tied", {31'h0, misalign_err}, 32'h0);
    chk("misalign req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("misalign req_addr", imem_req_addr, 32'h100);
    drive(0, 0, 32'h0, 0, 32'h0, 1);
`endif
    tick();

    // Asynchronous reset with a request outstanding and a valid IF/ID payload
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    tick();
    drive(0, 1, 32'hCAFE_0001, 0, 32'h0, 0);
    tick();
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("pre-reset id_valid", {31'h0, id_valid}, 32'h1);
    chk("pre-reset id_instr", id_instr, 32'hCAFE_0001);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset id_valid", {31'h0, id_valid}, 32'h0);
    chk("async reset id_instr", id_instr, 32'h0);
    chk("async reset id_pc", id_pc, 32'h0);
    chk("async reset id_pc_plus4", id_pc_plus4, 32'h0);
    chk("async reset req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("async reset req_addr", imem_req_addr, 32'h0);
    drive(0, 1, 32'hBAD0_0000, 0, 32'h0, 0);
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    chk("post-reset req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("post-reset req_addr", imem_req_addr, 32'h0);
    chk("post-reset id_valid", {31'h0, id_valid}, 32'h0);
    tick();

    // Randomized run: decode must see the program stream in order, restarting at each redirect
    mem_busy = 1'b0;
    mem_cnt  = 0;
    mem_addr = 32'h0;
    exp_pc   = 32'h0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
        end else begin
          mem_cnt--;
        end
      end
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) redirect_pc = redirect_pc | 32'hFFFF_FC00;
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_pc = redirect_pc & ~32'h3;
`endif
      @(negedge clk);
      if (id_valid && id_ready) begin
        chk("rand id_pc", id_pc, exp_pc);
        chk("rand id_instr", id_instr, mem_word(exp_pc));
        chk("rand id_pc_plus4", id_pc_plus4, exp_pc + 32'h4);
        exp_pc = exp_pc + 32'h4;
        consumed++;
      end
      if (imem_rsp_valid) mem_busy = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        chk("rand single outstanding", {31'h0, mem_busy}, 32'h0);
        mem_busy = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = $urandom_range(1, 4);
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      tick();
    end
    checks++;
    if (consumed < 100) begin
      errors++;
      $display("FAIL rand progress: got %0d instructions consumed, required at least 100", consumed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
